// File: rtl/blink_defs.sv
// Shared definitions for the blink decoder.
// Holds the FSM state encoding, the run-length saturation value and the
// helper functions used when validating and indexing a measured run.
package blink_defs;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [15:0] MAX_RUN = 16'h8000;

  // Position of the (single) set bit of a one-hot word.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // True for a nonzero power of two.
  function automatic logic is_pow2(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

endpackage

// File: rtl/blink_sync.sv
// Input synchronizer and edge detector for the blink decoder.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset (clears all flops)
//   async_i - asynchronous input level
//   s_o     - synchronized level (last synchronizer flop)
//   edge_o  - high for one cycle after each transition of s_o
// Rising and falling transitions see the same latency, so run lengths
// measured between edges equal the run lengths at the pin.
module blink_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic s_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign edge_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/blink_decoder.sv
// Blink decoder: recovers the one-hot mask that produced a blink waveform
// (high 2^k cycles, low 2^k cycles) by measuring run lengths between edges.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   blink_in  - asynchronous blink signal
//   mask_out  - recovered one-hot mask, 0 while not locked
//   bit_idx   - log2(mask_out), 0 while not locked
//   locked    - high while the decoded period is stable
//   err_pulse - one-cycle pulse on a rejected run or loss of lock
module blink_decoder #(
  parameter int LOCK_RUNS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blink_in,
  output logic [15:0] mask_out,
  output logic [3:0]  bit_idx,
  output logic        locked,
  output logic        err_pulse
);
  import blink_defs::*;

  localparam logic [3:0] LOCK_N = 4'(LOCK_RUNS);

  logic        lvl_w;
  logic        edge_w;

  state_e      state_q, state_d;
  logic [15:0] run_cnt_q, run_cnt_d;
  logic [15:0] cand_q, cand_d;
  logic [3:0]  match_q, match_d;
  logic [15:0] mask_q, mask_d;
  logic [3:0]  idx_q, idx_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;

  blink_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (blink_in),
    .s_o     (lvl_w),
    .edge_o  (edge_w)
  );

  // Run length: value held in the edge cycle is the length of the run just
  // ended; saturation keeps long idle periods from wrapping to short runs.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (edge_w)                    run_cnt_d = 16'd1;
    else if (run_cnt_q != MAX_RUN) run_cnt_d = run_cnt_q + 16'd1;
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    match_d  = match_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    case (state_q)
      // First edge only marks the start of a measurable run.
      SEARCH: begin
        if (edge_w) begin
          state_d = ACQUIRE;
          cand_d  = '0;
          match_d = '0;
        end
      end
      ACQUIRE: begin
        if (edge_w) begin
          if (is_pow2(run_cnt_q) && (cand_q == 16'd0 || run_cnt_q == cand_q)) begin
            cand_d  = run_cnt_q;
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == LOCK_N) begin
              state_d  = LOCKED;
              mask_d   = run_cnt_q;
              idx_d    = onehot_to_idx(run_cnt_q);
              locked_d = 1'b1;
            end
          end else if (is_pow2(run_cnt_q)) begin
            // A valid but different period restarts counting from this run.
            cand_d  = run_cnt_q;
            match_d = 4'd1;
            err_d   = 1'b1;
          end else begin
            cand_d  = '0;
            match_d = '0;
            err_d   = 1'b1;
          end
        end else if (run_cnt_q == MAX_RUN) begin
          // Signal went idle: quietly fall back without flagging an error.
          state_d = SEARCH;
          cand_d  = '0;
          match_d = '0;
        end
      end
      LOCKED: begin
        // Edge wins over the too-long check when both happen together.
        if ((edge_w && run_cnt_q != cand_q) || (!edge_w && run_cnt_q == cand_q)) begin
          state_d  = ACQUIRE;
          cand_d   = '0;
          match_d  = '0;
          mask_d   = '0;
          idx_d    = '0;
          locked_d = 1'b0;
          err_d    = 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEARCH;
      run_cnt_q <= '0;
      cand_q    <= '0;
      match_q   <= '0;
      mask_q    <= '0;
      idx_q     <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
    end
  end

  assign mask_out  = mask_q;
  assign bit_idx   = idx_q;
  assign locked    = locked_q;
  assign err_pulse = err_q;

endmodule

// File: tb/tb_blink_decoder.sv
// Bench for blink_decoder: drives blink waveforms described as lists of run
// lengths and compares every cycle against a run-level reference model.
module tb_blink_decoder;

  localparam int LOCK_RUNS = 4;
  localparam int SYNC      = 2;
  localparam int MAXR      = 32768;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        blink_in = 1'b0;
  logic [15:0] mask_out;
  logic [3:0]  bit_idx;
  logic        locked;
  logic        err_pulse;

  int n_pass  = 0;
  int n_total = 0;

  int          rq[$];
  bit          edge_at[];
  logic [15:0] e_mask[];
  logic [3:0]  e_idx[];
  logic        e_lk[];
  logic        e_err[];

  blink_decoder #(.LOCK_RUNS(LOCK_RUNS), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .blink_in  (blink_in),
    .mask_out  (mask_out),
    .bit_idx   (bit_idx),
    .locked    (locked),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d: got %h expected %h", tag, k, obs, exp);
  endtask

  function automatic bit pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Reference: walks the edge times; decision in slot d is visible at d+1.
  task automatic build_model(input int n);
    int mode, cand, match, pe, len;
    logic lk, er;
    logic [15:0] mk;
    logic [3:0]  ix;
    e_mask = new[n + 1];
    e_idx  = new[n + 1];
    e_lk   = new[n + 1];
    e_err  = new[n + 1];
    mode = 0; cand = 0; match = 0; pe = 0;
    lk = 1'b0; mk = '0; ix = '0;
    e_mask[0] = '0; e_idx[0] = '0; e_lk[0] = 1'b0; e_err[0] = 1'b0;
    for (int d = 0; d < n; d++) begin
      er = 1'b0;
      if (edge_at[d]) begin
        len = d - pe;
        if (len > MAXR) len = MAXR;
        if (mode == 0) begin
          mode = 1; cand = 0; match = 0;
        end else if (mode == 1) begin
          if (pow2(len) && (cand == 0 || len == cand)) begin
            cand = len; match++;
            if (match == LOCK_RUNS) begin
              mode = 2; lk = 1'b1; mk = 16'(len); ix = 4'($clog2(len));
            end
          end else if (pow2(len)) begin
            cand = len; match = 1; er = 1'b1;
          end else begin
            cand = 0; match = 0; er = 1'b1;
          end
        end else if (len != cand) begin
          mode = 1; cand = 0; match = 0; lk = 1'b0; mk = '0; ix = '0; er = 1'b1;
        end
        pe = d;
      end else if (mode == 1 && d - pe == MAXR) begin
        mode = 0; cand = 0; match = 0;
      end else if (mode == 2 && d - pe == cand) begin
        mode = 1; cand = 0; match = 0; lk = 1'b0; mk = '0; ix = '0; er = 1'b1;
      end
      e_mask[d + 1] = mk; e_idx[d + 1] = ix; e_lk[d + 1] = lk; e_err[d + 1] = er;
    end
  endtask

  task automatic check_cycle(input string tag, input int k);
    chk({tag, ".mask"},   k, mask_out,             e_mask[k]);
    chk({tag, ".idx"},    k, {12'd0, bit_idx},     {12'd0, e_idx[k]});
    chk({tag, ".locked"}, k, {15'd0, locked},      {15'd0, e_lk[k]});
    chk({tag, ".err"},    k, {15'd0, err_pulse},   {15'd0, e_err[k]});
  endtask

  // Reset, then toggle blink_in at first_off and after each run in rq.
  task automatic run_scenario(input string tag, input int first_off, input int hold);
    int tog[$];
    int t, n, ti;
    t = first_off;
    tog.push_back(t);
    foreach (rq[i]) begin
      t += rq[i];
      tog.push_back(t);
    end
    n = t + hold;
    edge_at = new[n];
    foreach (tog[i]) if (tog[i] + SYNC < n) edge_at[tog[i] + SYNC] = 1'b1;
    build_model(n);
    rst = 1'b1;
    blink_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    ti = 0;
    for (int k = 0; k < n; k++) begin
      check_cycle(tag, k);
      if (ti < tog.size() && tog[ti] == k) begin
        blink_in = ~blink_in;
        ti++;
      end
      @(posedge clk);
      #1;
    end
    check_cycle(tag, n);
  endtask

  task automatic pulse_reset_and_check(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk({tag, ".mask"},   0, mask_out,           16'd0);
    chk({tag, ".idx"},    0, {12'd0, bit_idx},   16'd0);
    chk({tag, ".locked"}, 0, {15'd0, locked},    16'd0);
    chk({tag, ".err"},    0, {15'd0, err_pulse}, 16'd0);
  endtask

  task automatic fill(input int len, input int count);
    for (int i = 0; i < count; i++) rq.push_back(len);
  endtask

  initial begin
    int prev;

    // mask 0x0008 blinker, random partial first run
    rq.delete(); fill(8, 6);
    run_scenario("m8", $urandom_range(1, 8), 6);

    // mask 0x0001: toggle every cycle
    rq.delete(); fill(1, 8);
    run_scenario("m1", 3, 6);

    // non power-of-two runs never lock
    rq.delete(); fill(3, 5);
    run_scenario("r3", 2, 6);

    // lock at 8, then period changes to 16
    rq.delete(); fill(8, 6); fill(16, 6);
    run_scenario("m8to16", 4, 8);

    // lock at 8, then input stuck: loss of lock then silent idle
    rq.delete(); fill(8, 6);
    run_scenario("stuck", 5, 40000);

    // reset while locked (scenario ends still locked)
    rq.delete(); fill(8, 5);
    run_scenario("prelock", 3, 4);
    pulse_reset_and_check("rst_locked");

    // reset mid-acquire
    rq.delete(); fill(4, 3);
    run_scenario("preacq", 2, 2);
    pulse_reset_and_check("rst_acq");

    // fresh lock after reset needs 1+LOCK_RUNS edges again
    rq.delete(); fill(2, 6);
    run_scenario("relock", 1, 6);

    // randomized run sequences, biased toward repeated powers of two
    for (int s = 0; s < 6; s++) begin
      rq.delete();
      prev = 1 << $urandom_range(0, 4);
      for (int i = 0; i < 30; i++) begin
        if (i > 0 && $urandom_range(0, 3) != 0) begin
          rq.push_back(prev);
        end else begin
          if ($urandom_range(0, 1) == 1) prev = 1 << $urandom_range(0, 4);
          else prev = $urandom_range(1, 20);
          rq.push_back(prev);
        end
      end
      run_scenario("rand", $urandom_range(1, 10), 40);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
